// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the IF -> ID -> EX core.
// Arbitrates jump, multi-cycle op, bus hold and load-use causes and
// drives per-register hold/flush strobes combinationally from state.
module pipe_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int BUS_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              multi_start_i,
    input  logic              multi_done_i,
    input  logic              bus_hold_i,
    input  logic              load_use_i,
    input  logic              cnt_clr_i,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              hold_pc_o,
    output logic              hold_if_o,
    output logic              hold_id_o,
    output logic              flush_if_o,
    output logic              flush_id_o,
    output logic [1:0]        state_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LDST  = 2'd1,
        MULTI = 2'd2,
        BUSW  = 2'd3
    } state_t;

    localparam logic [7:0] BUS_TO = BUS_TIMEOUT[7:0];

    state_t           r_state, w_next;
    logic [7:0]       r_bus_cnt, w_bus_cnt_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_jump, w_hold_pc, w_hold_if, w_hold_id, w_flush_if, w_flush_id;
    logic w_bus_blocked;

    // LDST entered from a bus timeout refuses the bus for that one cycle,
    // so a stuck master cannot immediately re-freeze the core.
    assign w_bus_blocked = (r_state == LDST) && r_timeout;

    // Next-state, bus counter and strobe decode
    always_comb begin
        w_next        = r_state;
        w_bus_cnt_nxt = r_bus_cnt;
        w_timeout_nxt = 1'b0;
        w_jump        = 1'b0;
        w_hold_pc     = 1'b0;
        w_hold_if     = 1'b0;
        w_hold_id     = 1'b0;
        w_flush_if    = 1'b0;
        w_flush_id    = 1'b0;
        case (r_state)
            RUN, LDST: begin
                if (jump_flag_i) begin
                    w_jump     = 1'b1;
                    w_flush_if = 1'b1;
                    w_flush_id = 1'b1;
                    w_next     = RUN;
                end else if (multi_start_i) begin
                    w_hold_pc = 1'b1;
                    w_hold_if = 1'b1;
                    w_hold_id = 1'b1;
                    w_next    = MULTI;
                end else if (bus_hold_i && !w_bus_blocked) begin
                    w_hold_pc     = 1'b1;
                    w_hold_if     = 1'b1;
                    w_hold_id     = 1'b1;
                    w_bus_cnt_nxt = 8'd1;
                    w_next        = BUSW;
                end else if (load_use_i && (r_state == RUN)) begin
                    // one bubble: freeze fetch side, NOP into ID/EX
                    w_hold_pc  = 1'b1;
                    w_hold_if  = 1'b1;
                    w_flush_id = 1'b1;
                    w_next     = LDST;
                end else begin
                    w_next = RUN;
                end
            end
            MULTI: begin
                if (!multi_done_i) begin
                    w_hold_pc = 1'b1;
                    w_hold_if = 1'b1;
                    w_hold_id = 1'b1;
                end else begin
                    w_next = RUN;
                end
            end
            BUSW: begin
                if (!bus_hold_i) begin
                    w_bus_cnt_nxt = 8'd0;
                    w_next        = RUN;
                end else if (r_bus_cnt < BUS_TO) begin
                    w_hold_pc     = 1'b1;
                    w_hold_if     = 1'b1;
                    w_hold_id     = 1'b1;
                    w_bus_cnt_nxt = r_bus_cnt + 8'd1;
                end else begin
                    w_bus_cnt_nxt = 8'd0;
                    w_timeout_nxt = 1'b1;
                    w_next        = LDST;
                end
            end
            default: w_next = RUN;
        endcase
    end

    // State, bus counter and timeout pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_bus_cnt <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_bus_cnt <= w_bus_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_stall_cnt <= '0;
        end else if (hold_pc_o && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign jump_flag_o = w_jump & ~rst;
    assign jump_addr_o = (w_jump && !rst) ? jump_addr_i : '0;
    assign hold_pc_o   = w_hold_pc & ~rst;
    assign hold_if_o   = w_hold_if & ~rst;
    assign hold_id_o   = w_hold_id & ~rst;
    assign flush_if_o  = w_flush_if & ~rst;
    assign flush_id_o  = w_flush_id & ~rst;
    assign state_o     = r_state;
    assign timeout_o   = r_timeout;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl (BUS_TIMEOUT=4).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_i = 1'b0, multi_start_i = 1'b0, multi_done_i = 1'b0;
    logic        bus_hold_i = 1'b0, load_use_i = 1'b0, cnt_clr_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        jump_flag_o, hold_pc_o, hold_if_o, hold_id_o, flush_if_o, flush_id_o, timeout_o;
    logic [31:0] jump_addr_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(32), .BUS_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .multi_start_i(multi_start_i), .multi_done_i(multi_done_i),
        .bus_hold_i(bus_hold_i), .load_use_i(load_use_i), .cnt_clr_i(cnt_clr_i),
        .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
        .hold_pc_o(hold_pc_o), .hold_if_o(hold_if_o), .hold_id_o(hold_id_o),
        .flush_if_o(flush_if_o), .flush_id_o(flush_id_o),
        .state_o(state_o), .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o)
    );

    typedef struct packed {
        logic jf, ms, md, bh, lu, clr;
        logic [31:0] addr;
    } stim_t;

    typedef struct packed {
        logic        jf;
        logic [2:0]  hold;   // {pc, if, id}
        logic        fi, fd;
        logic [1:0]  st;
        logic        to;
        logic [31:0] addr;
    } exp_t;

    stim_t       stim_q[$];
    exp_t        exp_q[$];
    logic [15:0] cnt_q[$];

    function automatic stim_t S(input logic jf, ms, md, bh, lu, clr, input logic [31:0] a);
        return '{jf: jf, ms: ms, md: md, bh: bh, lu: lu, clr: clr, addr: a};
    endfunction

    function automatic exp_t E(input logic jf, input logic [2:0] h, input logic fi, fd,
                               input logic [1:0] st, input logic to, input logic [31:0] a);
        return '{jf: jf, hold: h, fi: fi, fd: fd, st: st, to: to, addr: a};
    endfunction

    function automatic exp_t observe();
        return '{jf: jump_flag_o, hold: {hold_pc_o, hold_if_o, hold_id_o},
                 fi: flush_if_o, fd: flush_id_o, st: state_o, to: timeout_o, addr: jump_addr_o};
    endfunction

    task automatic apply(input stim_t s);
        jump_flag_i   = s.jf;
        multi_start_i = s.ms;
        multi_done_i  = s.md;
        bus_hold_i    = s.bh;
        load_use_i    = s.lu;
        cnt_clr_i     = s.clr;
        jump_addr_i   = s.addr;
    endtask

    task automatic test_reset();
        exp_t got, e;
        apply(S(1, 0, 0, 1, 1, 0, 32'hDEAD_BEEF));
        exp_q.push_back(E(0, 3'b000, 0, 0, 2'd0, 0, 32'h0));
        cnt_q.push_back(16'h0);
        #2;
        got = observe();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", got, e); end
        e.addr = {16'h0, cnt_q.pop_front()};
        checks++;
        if (stall_cnt_o !== e.addr[15:0]) begin
            errors++; $display("FAIL reset_stall got=%h exp=%h", stall_cnt_o, e.addr[15:0]);
        end
        apply(S(0, 0, 0, 0, 0, 0, 32'h0));
        #5 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_jump();
        exp_t got, e;
        int n = 0;
        stim_q.push_back(S(1, 0, 0, 0, 0, 0, 32'h0000_0100));
        exp_q.push_back(E(1, 3'b000, 1, 1, 2'd0, 0, 32'h0000_0100));
        stim_q.push_back(S(0, 0, 0, 0, 0, 0, 32'h0000_0100));
        exp_q.push_back(E(0, 3'b000, 0, 0, 2'd0, 0, 32'h0));
        stim_q.push_back(S(1, 0, 0, 0, 1, 0, 32'h0000_2000));
        exp_q.push_back(E(1, 3'b000, 1, 1, 2'd0, 0, 32'h0000_2000));
        stim_q.push_back(S(0, 0, 0, 0, 0, 0, 32'h0));
        exp_q.push_back(E(0, 3'b000, 0, 0, 2'd0, 0, 32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #2;
            got = observe(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL jump cyc=%0d got=%h exp=%h", n, got, e); end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_load_use();
        exp_t got, e;
        int n = 0;
        // held for two cycles: second cycle (LDST) is ignored
        stim_q.push_back(S(0, 0, 0, 0, 1, 0, 32'h0)); exp_q.push_back(E(0, 3'b110, 0, 1, 2'd0, 0, 32'h0));
        stim_q.push_back(S(0, 0, 0, 0, 1, 0, 32'h0)); exp_q.push_back(E(0, 3'b000, 0, 0, 2'd1, 0, 32'h0));
        stim_q.push_back(S(0, 0, 0, 0, 0, 0, 32'h0)); exp_q.push_back(E(0, 3'b000, 0, 0, 2'd0, 0, 32'h0));
        // second hazard from RUN gives a fresh bubble
        stim_q.push_back(S(0, 0, 0, 0, 1, 0, 32'h0)); exp_q.push_back(E(0, 3'b110, 0, 1, 2'd0, 0, 32'h0));
        stim_q.push_back(S(0, 0, 0, 0, 0, 0, 32'h0)); exp_q.push_back(E(0, 3'b000, 0, 0, 2'd1, 0, 32'h0));
        stim_q.push_back(S(0, 0, 0, 0, 0, 0, 32'h0)); exp_q.push_back(E(0, 3'b000, 0, 0, 2'd0, 0, 32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #2;
            got = observe(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL load_use cyc=%0d got=%h exp=%h", n, got, e); end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_multi();
        exp_t got, e;
        int n = 0;
        stim_q.push_back(S(0, 0, 0, 0, 0, 1, 32'h0)); exp_q.push_back(E(0, 3'b000, 0, 0, 2'd0, 0, 32'h0));
        stim_q.push_back(S(0, 1, 0, 0, 0, 0, 32'h0)); exp_q.push_back(E(0, 3'b111, 0, 0, 2'd0, 0, 32'h0));
        for (int i = 0; i < 32; i++) begin
            // a jump and load-use inside MULTI must be ignored
            stim_q.push_back(S(i == 10, 0, 0, 0, i == 15, 0, 32'h0000_0400));
            exp_q.push_back(E(0, 3'b111, 0, 0, 2'd2, 0, 32'h0));
        end
        stim_q.push_back(S(0, 0, 1, 0, 0, 0, 32'h0)); exp_q.push_back(E(0, 3'b000, 0, 0, 2'd2, 0, 32'h0));
        stim_q.push_back(S(0, 0, 0, 0, 0, 0, 32'h0)); exp_q.push_back(E(0, 3'b000, 0, 0, 2'd0, 0, 32'h0));
        cnt_q.push_back(16'd33);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #2;
            got = observe(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL multi cyc=%0d got=%h exp=%h", n, got, e); end
            @(posedge clk); #1; n++;
        end
        #2;
        checks++;
        if (stall_cnt_o !== cnt_q[0]) begin
            errors++; $display("FAIL multi_stall_cnt got=%0d exp=%0d", stall_cnt_o, cnt_q[0]);
        end
        void'(cnt_q.pop_front());
        @(posedge clk); #1;
    endtask

    task automatic test_bus_timeout();
        exp_t got, e;
        int n = 0;
        for (int i = 0; i < 8; i++) stim_q.push_back(S(0, 0, 0, 1, 0, 0, 32'h0));
        exp_q.push_back(E(0, 3'b111, 0, 0, 2'd0, 0, 32'h0));
        exp_q.push_back(E(0, 3'b111, 0, 0, 2'd3, 0, 32'h0));
        exp_q.push_back(E(0, 3'b111, 0, 0, 2'd3, 0, 32'h0));
        exp_q.push_back(E(0, 3'b111, 0, 0, 2'd3, 0, 32'h0));
        exp_q.push_back(E(0, 3'b000, 0, 0, 2'd3, 0, 32'h0));
        exp_q.push_back(E(0, 3'b000, 0, 0, 2'd1, 1, 32'h0));
        exp_q.push_back(E(0, 3'b111, 0, 0, 2'd0, 0, 32'h0));
        exp_q.push_back(E(0, 3'b111, 0, 0, 2'd3, 0, 32'h0));
        // normal release
        stim_q.push_back(S(0, 0, 0, 0, 0, 0, 32'h0)); exp_q.push_back(E(0, 3'b000, 0, 0, 2'd3, 0, 32'h0));
        stim_q.push_back(S(0, 0, 0, 0, 0, 0, 32'h0)); exp_q.push_back(E(0, 3'b000, 0, 0, 2'd0, 0, 32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #2;
            got = observe(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL bus_timeout cyc=%0d got=%h exp=%h", n, got, e); end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_counter_sat();
        logic [15:0] c;
        apply(S(0, 0, 0, 0, 0, 1, 32'h0));
        @(posedge clk); #1;
        apply(S(0, 1, 0, 0, 0, 0, 32'h0));
        @(posedge clk); #1;
        apply(S(0, 0, 0, 0, 0, 0, 32'h0));
        repeat (65535) @(posedge clk);
        #1;
        cnt_q.push_back(16'hFFFF);
        cnt_q.push_back(16'hFFFF);
        cnt_q.push_back(16'h0000);
        cnt_q.push_back(16'h0001);
        c = cnt_q.pop_front(); checks++;
        if (stall_cnt_o !== c) begin errors++; $display("FAIL cnt_saturate got=%h exp=%h", stall_cnt_o, c); end
        @(posedge clk); #1;
        c = cnt_q.pop_front(); checks++;
        if (stall_cnt_o !== c) begin errors++; $display("FAIL cnt_hold_sat got=%h exp=%h", stall_cnt_o, c); end
        apply(S(0, 0, 0, 0, 0, 1, 32'h0));  // clear while still stalled
        @(posedge clk); #1;
        apply(S(0, 0, 0, 0, 0, 0, 32'h0));
        c = cnt_q.pop_front(); checks++;
        if (stall_cnt_o !== c) begin errors++; $display("FAIL cnt_clear got=%h exp=%h", stall_cnt_o, c); end
        @(posedge clk); #1;
        c = cnt_q.pop_front(); checks++;
        if (stall_cnt_o !== c) begin errors++; $display("FAIL cnt_after_clr got=%h exp=%h", stall_cnt_o, c); end
        apply(S(0, 0, 1, 0, 0, 0, 32'h0));
        @(posedge clk); #1;
        apply(S(0, 0, 0, 0, 0, 0, 32'h0));
        #1;
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL cnt_exit_state got=%0d exp=0", state_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_multi();
        exp_t got, e;
        apply(S(0, 1, 0, 0, 0, 0, 32'h0));
        @(posedge clk); #1;
        apply(S(0, 0, 0, 0, 0, 0, 32'h0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_q.push_back(E(0, 3'b111, 0, 0, 2'd2, 0, 32'h0));
        got = observe(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL pre_reset_multi got=%h exp=%h", got, e); end
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(E(0, 3'b000, 0, 0, 2'd0, 0, 32'h0));
        cnt_q.push_back(16'h0);
        got = observe(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset_mid_multi got=%h exp=%h", got, e); end
        checks++;
        if (stall_cnt_o !== cnt_q[0]) begin
            errors++; $display("FAIL reset_mid_multi_cnt got=%h exp=%h", stall_cnt_o, cnt_q[0]);
        end
        void'(cnt_q.pop_front());
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(E(0, 3'b000, 0, 0, 2'd0, 0, 32'h0));
        got = observe(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL post_reset_idle got=%h exp=%h", got, e); end
    endtask

    initial begin
        #2;
        test_reset();
        test_jump();
        test_load_use();
        test_multi();
        test_bus_timeout();
        test_counter_sat();
        test_reset_mid_multi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // absolute time bound so the run always ends
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
